// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: drives the ROM address, buffers fetched words
// in a small prefetch FIFO and hands {pc, instr} pairs to decode.
//
// state | meaning
// RUN   | fetching one word per cycle while the FIFO has room
// FAULT | fetch PC was misaligned or past the ROM; fetching halted
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 1024,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        fault,
    output logic [31:0] fault_pc
);

    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [31:0]   fetch_pc;
    logic [31:0]   fault_pc_q;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic [31:0]   fifo_pc    [FIFO_DEPTH];
    logic [31:0]   fifo_instr [FIFO_DEPTH];

    logic pc_legal;
    logic pop;
    logic push;
    logic fault_set;

    // Full 32-bit range compare so high address bits can never alias into the ROM.
    assign pc_legal  = (fetch_pc[1:0] == 2'b00) && (fetch_pc <= LAST_PC);
    assign pop       = out_valid & out_ready;
    assign push      = (state == RUN) && !redirect_valid && pc_legal &&
                       ((count < DEPTH_C) || pop);
    assign fault_set = (state == RUN) && !redirect_valid && !pc_legal;

    assign imem_addr = fetch_pc;
    assign out_valid = (count != '0);
    assign out_instr = out_valid ? fifo_instr[rd_ptr] : 32'h0;
    assign out_pc    = out_valid ? fifo_pc[rd_ptr]    : 32'h0;
    assign fault     = (state == FAULT);
    assign fault_pc  = fault ? fault_pc_q : 32'h0;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    // Next state: a redirect always restarts fetching, even out of FAULT.
    always_comb begin
        state_nxt = state;
        if (redirect_valid)  state_nxt = RUN;
        else if (fault_set)  state_nxt = FAULT;
    end

    // Fetch PC, FIFO pointers/occupancy and captured fault address.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc   <= RESET_PC;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            fault_pc_q <= 32'h0;
        end else if (redirect_valid) begin
            // Flush wins over any pop presented in the same cycle.
            fetch_pc   <= redirect_pc;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            fault_pc_q <= 32'h0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + 1'b1;
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (fault_set) fault_pc_q <= fetch_pc;
        end
    end

    // FIFO storage; contents are qualified by count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]    <= fetch_pc;
            fifo_instr[wr_ptr] <= imem_data;
        end
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences the combinational, byte-addressed instruction ROM for the RV32I core.
- Owns the fetch PC, presents one word address per cycle to the ROM and captures the returned word into a small prefetch FIFO.
- Hands {pc, instruction} pairs to decode over a valid/ready handshake.
- Handles control-flow redirects (flush and restart) and traps fetches that are misaligned or beyond the ROM.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset; must be 4-byte aligned.
- IMEM_BYTES, 1024, ROM size in bytes; legal fetch PCs are 0 .. IMEM_BYTES-4.
- FIFO_DEPTH, 2, prefetch entries (power of two, >=2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- imem_addr  output  32  byte address to the ROM; always equals fetch_pc.
- imem_data  input  32  ROM word for imem_addr, valid in the same cycle.
- redirect_valid  input  1  branch/jump/trap redirect request.
- redirect_pc  input  32  new fetch target.
- out_valid  output  1  FIFO head holds a valid instruction.
- out_ready  input  1  decode accepts the head this cycle.
- out_instr  output  32  head instruction; 0 when empty.
- out_pc  output  32  head PC; 0 when empty.
- fault  output  1  fetch fault latched; fetching halted.
- fault_pc  output  32  offending PC while fault=1; 0 otherwise.

Behaviour:
- Interface: one clock (clk); rst is synchronous and active-high.
- Reset (sampled at a rising edge with rst=1):
  - fetch_pc=RESET_PC, FIFO emptied, state=RUN.
  - out_valid=0, out_instr=0, out_pc=0, fault=0, fault_pc=0.
  - Reset mid-operation discards all entries and any pending redirect.
- States:
  - RUN: fetching.
  - FAULT: halted; fault=1.
- pop = out_valid & out_ready.
- push (RUN, no redirect, PC legal) occurs when count<FIFO_DEPTH, or count==FIFO_DEPTH with pop in the same cycle.
- On push, {fetch_pc, imem_data} is written at the tail and fetch_pc += 4.
- Simultaneous push and pop with count==FIFO_DEPTH keeps count unchanged.
- Throughput: one instruction per cycle while out_ready=1.
- Latency:
  - An instruction is pushed at edge N and visible on out_* after edge N.
  - First out_valid=1 follows the first edge with rst=0.
- Legal PC: pc[1:0]==0 and pc <= IMEM_BYTES-4.
- Fault entry:
  - If in RUN fetch_pc is illegal and no redirect is present, next edge goes to FAULT with fault_pc=fetch_pc.
  - No push occurs; entries already in the FIFO still drain normally.
- No wrap-around: after IMEM_BYTES-4, fetch_pc becomes IMEM_BYTES, which is an illegal PC and faults.
- Redirect (any state, redirect_valid=1 at an edge):
  - FIFO flushed, fetch_pc <= redirect_pc, state <= RUN, fault and fault_pc cleared.
  - No push that cycle; a pop in the same cycle is discarded (the flush wins).
  - out_valid is 0 the cycle after the redirect; the target instruction appears one edge later (2-cycle redirect penalty).
  - A misaligned or out-of-range redirect_pc faults on the following edge via the rule above.
- Redirect and rst together: rst wins.
- Handshake rules:
  - out_instr and out_pc are stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a pop, redirect or reset.
- Arithmetic: PC increment is 32-bit modulo.
- Range check uses the full 32-bit compare, not truncated to the ROM address width.

Test Plan:
1. Reset and stream:
   - Stimulus: ROM words 0x00000013, 0x00100093, 0x00200113 at bytes 0,4,8; out_ready=1 from reset release.
   - Required: out_pc 0,4,8 on consecutive cycles with matching out_instr; out_valid=0 during rst.
2. Backpressure:
   - Stimulus: out_ready=0 for 5 cycles.
   - Required: FIFO fills to 2; imem_addr holds at 8; out_pc stays 0 / out_instr 0x00000013 stable.
   - Then out_ready=1: PCs 0,4,8,12 arrive with no gap or duplicate.
3. Redirect:
   - Stimulus: redirect_valid for one cycle with redirect_pc=0x40, while out_valid=1 and out_ready=1.
   - Required: next cycle out_valid=0; following cycle out_pc=0x40; pre-redirect entries never appear.
4. End of ROM:
   - Stimulus: redirect to IMEM_BYTES-8 (1016).
   - Required: instructions at 1016 and 1020 are delivered; fault=1 with fault_pc=1024; imem_addr stops advancing.
   - Then redirect to 0: fault=0, and PC 0 is delivered two cycles later.
5. Misaligned target:
   - Stimulus: redirect_pc=0x6.
   - Required: fault=1, fault_pc=0x6, out_valid=0.
6. Reset while busy:
   - Stimulus: rst=1 for one cycle while the FIFO is full and in FAULT.
   - Required: all outputs return to reset values; fetching restarts from RESET_PC.
